cache_port_arbiter: RTL

//  Shares the single data cache between the instruction-fetch port (port 0, read-only) and the

---
 rtl/cache_arb_pkg.sv | 11 +
 rtl/cache_arb_picker.sv | 26 ++
 rtl/cache_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared FSM state encodings and port identifiers for the cache port arbiter
package cache_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/cache_arb_picker.sv
// rtl/cache_arb_picker.sv - combinational 2-way grant between fetch and load/store requesters
// CACHE_ARB_RR_EN selects round-robin on ties; otherwise the load/store port always wins.
module cache_arb_picker
  import cache_arb_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
`ifdef CACHE_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_any,
  output logic grant_port
);

  always_comb begin
    grant_any  = if_valid | ls_valid;
    grant_port = ls_valid ? PORT_LS : PORT_IF;
`ifdef CACHE_ARB_RR_EN
    // on a tie the port that lost last time goes first
    if (if_valid && ls_valid) begin
      grant_port = ~last_grant;
    end
`endif
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - shares one data cache between fetch and load/store ports, one access in flight
// CACHE_ARB_RR_EN enables round-robin arbitration on ties (default: fixed load/store priority).
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_valid,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_write,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              c_in_valid,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_read,
  output logic              c_write,
  output logic [DATA_W-1:0] c_din,
  input  logic              c_ready,
  input  logic              c_out_valid,
  input  logic [DATA_W-1:0] c_dout,
  input  logic              c_hit,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  logic [1:0] state;
  logic       owner;
  logic       lat_write;
  logic       grant_any;
  logic       grant_port;
  logic       take;

`ifdef CACHE_ARB_RR_EN
  logic       last_grant;
`endif

  cache_arb_picker u_picker (
    .if_valid   (if_valid),
    .ls_valid   (ls_valid),
`ifdef CACHE_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant_any  (grant_any),
    .grant_port (grant_port)
  );

  // acceptance is combinational so the ack lands in the same cycle the request is latched
  assign take   = !reset && (state == ST_IDLE) && c_ready && grant_any;
  assign if_ack = take && (grant_port == PORT_IF);
  assign ls_ack = take && (grant_port == PORT_LS);

  assign c_in_valid = (state == ST_ISSUE);
  assign c_read     = (state != ST_IDLE) && !lat_write;
  assign c_write    = (state != ST_IDLE) && lat_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner         <= PORT_IF;
      lat_write     <= 1'b0;
      c_addr        <= '0;
      c_din         <= '0;
      if_rdata      <= '0;
      ls_rdata      <= '0;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
`ifdef CACHE_ARB_RR_EN
      last_grant    <= PORT_LS;
`endif
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            owner <= grant_port;
`ifdef CACHE_ARB_RR_EN
            last_grant <= grant_port;
`endif
            if (grant_port == PORT_LS) begin
              c_addr    <= ls_addr;
              c_din     <= ls_wdata;
              lat_write <= ls_write;
            end else begin
              c_addr    <= if_addr;
              c_din     <= '0;
              lat_write <= 1'b0;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (c_out_valid) begin
            if (owner == PORT_LS) begin
              ls_rdata      <= c_dout;
              ls_resp_valid <= 1'b1;
            end else begin
              if_rdata      <= c_dout;
              if_resp_valid <= 1'b1;
            end
            if (c_hit) begin
              hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
